// File: rtl/md5_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | md5_sched_pkg                                                            |
// | State encodings, result status codes and defaults for md5_job_scheduler.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package md5_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WARM   = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_REPORT = 3'd5
  } sched_state_t;

  localparam logic [1:0] RES_NOT_FOUND = 2'b00;
  localparam logic [1:0] RES_FOUND     = 2'b01;
  localparam logic [1:0] RES_BAD_RANGE = 2'b10;
  localparam logic [1:0] RES_ABORTED   = 2'b11;

  localparam int DEF_PIPE_LAT = 64;

endpackage

`default_nettype wire

// File: rtl/md5_sched_counter.sv
// +--------------------------------------------------------------------------+
// | md5_sched_counter                                                        |
// | Issue/check base counters with end detect, flush load and warm-up count.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module md5_sched_counter #(
  parameter int CNT_W    = 29,
  parameter int PIPE_LAT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_start,
  input  logic [CNT_W-1:0] i_end,
  input  logic             i_issue_en,
  input  logic             i_warm_en,
  input  logic             i_check_en,
  output logic [CNT_W-1:0] o_issue,
  output logic [CNT_W-1:0] o_check,
  output logic             o_issue_at_end,
  output logic             o_check_at_end,
  output logic             o_warm_done
);

  localparam int                    c_WARM_W    = $clog2(PIPE_LAT + 1);
  localparam logic [c_WARM_W-1:0]   c_WARM_LAST = c_WARM_W'(PIPE_LAT - 1);

  logic [CNT_W-1:0]    r_issue;
  logic [CNT_W-1:0]    r_check;
  logic [c_WARM_W-1:0] r_warm;

  assign o_issue        = r_issue;
  assign o_check        = r_check;
  assign o_issue_at_end = (r_issue == i_end);
  assign o_check_at_end = (r_check == i_end);
  assign o_warm_done    = (r_warm == c_WARM_LAST);

  // Both counters stop at the job end, so a full-scale end value never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue <= '0;
      r_check <= '0;
      r_warm  <= '0;
    end else if (i_load) begin
      r_issue <= i_start;
      r_check <= i_start;
      r_warm  <= '0;
    end else begin
      if (i_issue_en && !o_issue_at_end) r_issue <= r_issue + CNT_W'(1);
      if (i_check_en && !o_check_at_end) r_check <= r_check + CNT_W'(1);
      if (i_warm_en)                     r_warm  <= r_warm + c_WARM_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/md5_job_scheduler.sv
// +--------------------------------------------------------------------------+
// | md5_job_scheduler                                                        |
// | Job sequencer for MD5 lanes; optional res_cycles via MD5_SCHED_CYCLES_EN.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module md5_job_scheduler
  import md5_sched_pkg::*;
#(
  parameter int CNT_W    = 29,
  parameter int LANE_W   = 1,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                    CLK,
  input  logic                    CPU_RESETN,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [127:0]            job_target,
  input  logic [CNT_W-1:0]        job_start,
  input  logic [CNT_W-1:0]        job_end,
  input  logic                    abort,
  output logic                    eng_flush,
  output logic [CNT_W-1:0]        eng_base,
  output logic [127:0]            eng_target,
  input  logic                    eng_found,
  input  logic [LANE_W-1:0]       eng_found_lane,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_status,
  output logic [CNT_W+LANE_W-1:0] res_candidate,
  output logic                    busy
`ifdef MD5_SCHED_CYCLES_EN
  ,
  output logic [31:0]             res_cycles
`endif
);

  sched_state_t              r_state;
  logic [CNT_W-1:0]          r_start;
  logic [CNT_W-1:0]          r_end;
  logic [127:0]              r_target;
  logic                      r_flush;
  logic                      r_res_valid;
  logic [1:0]                r_status;
  logic [CNT_W+LANE_W-1:0]   r_cand;

  logic                      w_accept;
  logic                      w_active;
  logic [CNT_W-1:0]          w_issue;
  logic [CNT_W-1:0]          w_check;
  logic                      w_issue_at_end;
  logic                      w_check_at_end;
  logic                      w_warm_done;

  assign w_accept = job_valid && (r_state == S_IDLE);
  assign w_active = (r_state == S_LOAD) || (r_state == S_WARM) ||
                    (r_state == S_RUN)  || (r_state == S_DRAIN);

  md5_sched_counter #(
    .CNT_W    (CNT_W),
    .PIPE_LAT (PIPE_LAT)
  ) u_counter (
    .clk            (CLK),
    .rst_n          (CPU_RESETN),
    .i_load         (r_state == S_LOAD),
    .i_start        (r_start),
    .i_end          (r_end),
    .i_issue_en     ((r_state == S_WARM) || (r_state == S_RUN)),
    .i_warm_en      (r_state == S_WARM),
    .i_check_en     ((r_state == S_RUN) || (r_state == S_DRAIN)),
    .o_issue        (w_issue),
    .o_check        (w_check),
    .o_issue_at_end (w_issue_at_end),
    .o_check_at_end (w_check_at_end),
    .o_warm_done    (w_warm_done)
  );

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state     <= S_IDLE;
      r_start     <= '0;
      r_end       <= '0;
      r_target    <= '0;
      r_flush     <= 1'b0;
      r_res_valid <= 1'b0;
      r_status    <= RES_NOT_FOUND;
      r_cand      <= '0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_target <= job_target;
            r_start  <= job_start;
            r_end    <= job_end;
            if (job_start > job_end) begin
              r_status    <= RES_BAD_RANGE;
              r_cand      <= '0;
              r_res_valid <= 1'b1;
              r_state     <= S_REPORT;
            end else begin
              r_flush <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD, S_WARM: begin
          if (abort) begin
            r_status    <= RES_ABORTED;
            r_cand      <= '0;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else if (r_state == S_LOAD) begin
            r_state <= S_WARM;
          end else if (w_warm_done) begin
            r_state <= w_issue_at_end ? S_DRAIN : S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          // Lane hits line up with the check counter; abort outranks a same-cycle hit.
          if (abort) begin
            r_status    <= RES_ABORTED;
            r_cand      <= '0;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else if (eng_found) begin
            r_status    <= RES_FOUND;
            r_cand      <= {w_check, eng_found_lane};
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else if (w_check_at_end) begin
            r_status    <= RES_NOT_FOUND;
            r_cand      <= '0;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else if ((r_state == S_RUN) && w_issue_at_end) begin
            r_state <= S_DRAIN;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MD5_SCHED_CYCLES_EN
  logic [31:0] r_cycles;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if (w_active && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign res_cycles = r_cycles;
`endif

  assign job_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign eng_flush     = r_flush;
  assign eng_base      = w_issue;
  assign eng_target    = r_target;
  assign res_valid     = r_res_valid;
  assign res_status    = r_status;
  assign res_candidate = r_cand;

endmodule

`default_nettype wire

// File: tb/tb_md5_job_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_md5_job_scheduler                                                     |
// | Randomized and directed self-checking bench for md5_job_scheduler.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_md5_job_scheduler;

  localparam int CNT_W    = 29;
  localparam int LANE_W   = 1;
  localparam int PIPE_LAT = 64;
  localparam int HW       = 256;
  localparam int MAXB     = (1 << CNT_W) - 1;

  logic                    CLK = 1'b0;
  logic                    CPU_RESETN = 1'b0;
  logic                    job_valid = 1'b0;
  logic                    job_ready;
  logic [127:0]            job_target = '0;
  logic [CNT_W-1:0]        job_start = '0;
  logic [CNT_W-1:0]        job_end = '0;
  logic                    abort = 1'b0;
  logic                    eng_flush;
  logic [CNT_W-1:0]        eng_base;
  logic [127:0]            eng_target;
  logic                    eng_found = 1'b0;
  logic [LANE_W-1:0]       eng_found_lane = '0;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic [1:0]              res_status;
  logic [CNT_W+LANE_W-1:0] res_candidate;
  logic                    busy;
`ifdef MD5_SCHED_CYCLES_EN
  logic [31:0]             res_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  md5_job_scheduler #(
    .CNT_W    (CNT_W),
    .LANE_W   (LANE_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .CLK            (CLK),
    .CPU_RESETN     (CPU_RESETN),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_target     (job_target),
    .job_start      (job_start),
    .job_end        (job_end),
    .abort          (abort),
    .eng_flush      (eng_flush),
    .eng_base       (eng_base),
    .eng_target     (eng_target),
    .eng_found      (eng_found),
    .eng_found_lane (eng_found_lane),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_status     (res_status),
    .res_candidate  (res_candidate),
    .busy           (busy)
`ifdef MD5_SCHED_CYCLES_EN
    ,
    .res_cycles     (res_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  // Lane model: a base presented in cycle t reports a hit PIPE_LAT cycles later.
  logic [CNT_W-1:0]  hist [HW];
  int                cyc = 0;
  bit                lane_hit_v = 1'b0;
  logic [CNT_W-1:0]  lane_hit_b = '0;
  logic [LANE_W-1:0] lane_hit_l = '0;

  always @(negedge CLK) begin
    hist[cyc % HW] = eng_base;
    if (cyc >= PIPE_LAT && lane_hit_v && hist[(cyc - PIPE_LAT) % HW] == lane_hit_b) begin
      eng_found      = 1'b1;
      eng_found_lane = lane_hit_l;
    end else begin
      eng_found      = 1'b0;
      eng_found_lane = LANE_W'($urandom_range(0, 1));
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result and timing from the job rules; cycle n counts edges after the accept edge.
  function automatic void model(input int s, input int e, input bit hv, input int hb,
                                input int hl, input int ab,
                                output int st, output int cand, output int rep);
    int k;
    int term;
    if (s > e) begin
      st = 2; cand = 0; rep = 1;
    end else begin
      if (hv && hb >= s && hb <= e) begin
        k = hb - s; st = 1; cand = (hb << LANE_W) | hl;
      end else begin
        k = e - s; st = 0; cand = 0;
      end
      term = PIPE_LAT + 2 + k;
      if (ab > 0 && ab <= term) begin
        st = 3; cand = 0; rep = ab + 1;
      end else begin
        rep = term + 1;
      end
    end
  endfunction

  task automatic run_job(input int s, input int e, input bit hv, input int hb, input int hl,
                         input int ab, input int rdly,
                         output int o_st, output int o_cand, output int o_rep);
    int exp_st, exp_cand, exp_rep, exb;
    logic [127:0] tgt;
    model(s, e, hv, hb, hl, ab, exp_st, exp_cand, exp_rep);
    tgt = {$urandom, $urandom, $urandom, $urandom};
    o_st = -1; o_cand = -1; o_rep = -1;
    @(negedge CLK);
    chk("idle_job_ready", 128'(job_ready), 128'(1));
    job_valid  = 1'b1;
    job_start  = CNT_W'(s);
    job_end    = CNT_W'(e);
    job_target = tgt;
    lane_hit_v = hv;
    lane_hit_b = CNT_W'(hb);
    lane_hit_l = LANE_W'(hl);
    abort      = 1'b0;
    for (int n = 1; n <= exp_rep + rdly; n++) begin
      @(negedge CLK);
      job_valid = 1'b0;
      abort     = (n == ab);
      chk("res_valid", 128'(res_valid), 128'(n >= exp_rep));
      chk("busy", 128'(busy), 128'(1));
      chk("job_ready_busy", 128'(job_ready), 128'(0));
      chk("eng_flush", 128'(eng_flush), 128'(n == 1 && s <= e));
      chk("eng_target", eng_target, tgt);
      if (s <= e && n >= 2 && n < exp_rep) begin
        exb = (s + n - 2 < e) ? s + n - 2 : e;
        chk("eng_base", 128'(eng_base), 128'(exb));
      end
      if (n >= exp_rep) begin
        chk("res_status", 128'(res_status), 128'(exp_st));
        chk("res_candidate", 128'(res_candidate), 128'(exp_cand));
`ifdef MD5_SCHED_CYCLES_EN
        chk("res_cycles", 128'(res_cycles), 128'(exp_rep - 1));
`endif
      end
      if (res_valid && o_rep < 0) begin
        o_rep  = n;
        o_st   = int'(res_status);
        o_cand = int'(res_candidate);
      end
      if (n == exp_rep + rdly) res_ready = 1'b1;
    end
    @(negedge CLK);
    res_ready = 1'b0;
    abort     = 1'b0;
    chk("ack_res_valid", 128'(res_valid), 128'(0));
    chk("ack_job_ready", 128'(job_ready), 128'(1));
    chk("ack_busy", 128'(busy), 128'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_job_ready"}, 128'(job_ready), 128'(1));
    chk({tag, "_res_valid"}, 128'(res_valid), 128'(0));
    chk({tag, "_eng_flush"}, 128'(eng_flush), 128'(0));
    chk({tag, "_eng_base"}, 128'(eng_base), 128'(0));
    chk({tag, "_eng_target"}, eng_target, 128'(0));
    chk({tag, "_res_status"}, 128'(res_status), 128'(0));
    chk({tag, "_res_candidate"}, 128'(res_candidate), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, cd, rp;
    int s, e, len, hb, ab;
    bit hv;

    repeat (3) @(negedge CLK);
    chk_reset_state("reset");
`ifdef MD5_SCHED_CYCLES_EN
    chk("reset_res_cycles", 128'(res_cycles), 128'(0));
`endif
    CPU_RESETN = 1'b1;
    repeat (2) @(negedge CLK);

    // Hit at base 37, lane 1.
    run_job(0, 1000, 1, 37, 1, 0, 0, st, cd, rp);
    chk("t1_status", 128'(st), 128'(1));
    chk("t1_cand", 128'(cd), 128'(75));
    chk("t1_latency", 128'(rp), 128'(104));

    // No hit over 11 bases.
    run_job(10, 20, 0, 0, 0, 0, 0, st, cd, rp);
    chk("t2_status", 128'(st), 128'(0));
    chk("t2_cand", 128'(cd), 128'(0));
    chk("t2_latency", 128'(rp), 128'(77));

    // Bad range; abort during REPORT is ignored.
    run_job(5, 4, 0, 0, 0, 1, 0, st, cd, rp);
    chk("t3_status", 128'(st), 128'(2));
    chk("t3_latency", 128'(rp), 128'(1));

    // Single-base range, hit at base 0 lane 0.
    run_job(0, 0, 1, 0, 0, 0, 0, st, cd, rp);
    chk("t4_status", 128'(st), 128'(1));
    chk("t4_cand", 128'(cd), 128'(0));
    chk("t4_latency", 128'(rp), 128'(67));

    // Abort in RUN cycle 30 coinciding with a hit.
    run_job(0, 1000, 1, 30, 1, PIPE_LAT + 32, 0, st, cd, rp);
    chk("t5_status", 128'(st), 128'(3));
    chk("t5_cand", 128'(cd), 128'(0));
    chk("t5_latency", 128'(rp), 128'(97));

    // Result held for 8 cycles of back-pressure.
    run_job(100, 105, 1, 103, 0, 0, 8, st, cd, rp);
    chk("t6_status", 128'(st), 128'(1));
    chk("t6_cand", 128'(cd), 128'(206));

    // Full-scale end: hit on the last base, then a no-hit run to the top.
    run_job(MAXB - 2, MAXB, 1, MAXB, 1, 0, 0, st, cd, rp);
    chk("t7_status", 128'(st), 128'(1));
    chk("t7_cand", 128'(cd), 128'((1 << (CNT_W + LANE_W)) - 1));
    chk("t7_latency", 128'(rp), 128'(69));
    run_job(MAXB - 1, MAXB, 0, 0, 0, 0, 0, st, cd, rp);
    chk("t8_status", 128'(st), 128'(0));

    // Asynchronous reset in the middle of RUN.
    @(negedge CLK);
    job_valid  = 1'b1;
    job_start  = '0;
    job_end    = CNT_W'(1000);
    job_target = {4{32'hA5A5_5A5A}};
    lane_hit_v = 1'b0;
    @(negedge CLK);
    job_valid = 1'b0;
    repeat (PIPE_LAT + 20) @(negedge CLK);
    chk("midrun_busy", 128'(busy), 128'(1));
    #2 CPU_RESETN = 1'b0;
    #1 chk_reset_state("async_reset");
    @(negedge CLK);
    CPU_RESETN = 1'b1;
    run_job(50, 60, 1, 55, 1, 0, 1, st, cd, rp);
    chk("t9_status", 128'(st), 128'(1));
    chk("t9_cand", 128'(cd), 128'(111));

    for (int j = 0; j < 40; j++) begin
      s   = $urandom_range(0, 300);
      len = $urandom_range(0, 40);
      if ($urandom_range(0, 9) == 0) begin
        e = s;
        s = s + 1 + $urandom_range(0, 5);
      end else begin
        e = s + len;
      end
      hv = ($urandom_range(0, 3) != 0);
      hb = s - 2 + $urandom_range(0, len + 4);
      if (hb < 0) hb = 0;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, PIPE_LAT + len + 6) : 0;
      run_job(s, e, hv, hb, $urandom_range(0, 1), ab, $urandom_range(0, 3), st, cd, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
